// File: rtl/mod_pkg.sv
// Shared definitions for the symbol mapper.
// Holds the mode encodings, the unpacker state enum, the 16-QAM Gray
// pair to level-index function and the bits-per-symbol function.
package mod_pkg;

  localparam logic [1:0] MODE_BPSK  = 2'b00;
  localparam logic [1:0] MODE_QPSK  = 2'b01;
  localparam logic [1:0] MODE_QAM16 = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  // Gray pair to ascending level index:
  // 00 -> 0 (-3u), 01 -> 1 (-u), 11 -> 2 (+u), 10 -> 3 (+3u)
  function automatic logic [1:0] gray_to_index(input logic [1:0] pair);
    return {pair[1], pair[1] ^ pair[0]};
  endfunction

  // The reserved mode 11 falls into the 16-QAM branch
  function automatic logic [2:0] bits_per_symbol(input logic [1:0] sel);
    case (sel)
      MODE_BPSK: return 3'd1;
      MODE_QPSK: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Two-entry circular word FIFO between the S2P stage and the unpacker.
// Ports:
//   CLK, RST     clock and asynchronous active-high reset
//   clear        synchronous empty (flush)
//   push, pop    write / read strobes; push while full is accepted only
//                together with a pop in the same cycle
//   push_word    word to store
//   head_word    oldest stored word
//   full, empty  occupancy flags
module word_fifo #(
  parameter int wordWidth = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 push,
  input  logic                 pop,
  input  logic [wordWidth-1:0] push_word,
  output logic [wordWidth-1:0] head_word,
  output logic                 full,
  output logic                 empty
);

  logic [wordWidth-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic                 do_push;
  logic                 do_pop;

  assign empty     = (count == 2'd0);
  assign full      = (count == 2'd2);
  assign head_word = mem[rd_ptr];

  // A pop frees the head slot in the same cycle, so a full FIFO can still
  // take a word when it is being read.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/symbol_mapper.sv
// Symbol mapper: buffers S2P words and unpacks them into BPSK, QPSK or
// Gray-coded 16-QAM I/Q amplitudes on a valid/ready output.
// Ports:
//   CLK, RST   clock and asynchronous active-high reset
//   start      enable; low flushes the block synchronously
//   dataIn     parallel word, MSB is the first serial bit
//   dataValid  one-cycle word strobe from the S2P stage
//   mode       00 BPSK, 01 QPSK, 10/11 16-QAM
//   symReady   downstream accepts the current symbol
//   symValid   iOut/qOut/symLast are valid
//   iOut, qOut signed amplitudes
//   symLast    symbol is the last one of its word
//   overflow   sticky, a word was dropped
//   busy       FIFO, unpacker or output register still occupied
module symbol_mapper
  import mod_pkg::*;
#(
  parameter int wordWidth = 4,
  parameter int ampWidth  = 8,
  parameter int qamUnit   = 32,
  parameter int pskAmp    = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [wordWidth-1:0] dataIn,
  input  logic                 dataValid,
  input  logic [1:0]           mode,
  input  logic                 symReady,
  output logic                 symValid,
  output logic [ampWidth-1:0]  iOut,
  output logic [ampWidth-1:0]  qOut,
  output logic                 symLast,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CW = $clog2(wordWidth);

  localparam logic signed [ampWidth-1:0] PSK_POS = ampWidth'(pskAmp);
  localparam logic signed [ampWidth-1:0] PSK_NEG = ampWidth'(-pskAmp);
  localparam logic signed [ampWidth-1:0] QAM_M3  = ampWidth'(-3 * qamUnit);
  localparam logic signed [ampWidth-1:0] QAM_M1  = ampWidth'(-qamUnit);
  localparam logic signed [ampWidth-1:0] QAM_P1  = ampWidth'(qamUnit);
  localparam logic signed [ampWidth-1:0] QAM_P3  = ampWidth'(3 * qamUnit);

  function automatic logic [ampWidth-1:0] qam_level(input logic [1:0] index);
    case (index)
      2'd0:    return QAM_M3;
      2'd1:    return QAM_M1;
      2'd2:    return QAM_P1;
      default: return QAM_P3;
    endcase
  endfunction

  // Index of the final symbol in a word; the counter runs down to zero
  function automatic logic [CW-1:0] last_index(input logic [1:0] sel);
    case (sel)
      MODE_BPSK: return CW'(wordWidth - 1);
      MODE_QPSK: return CW'(wordWidth / 2 - 1);
      default:   return CW'(wordWidth / 4 - 1);
    endcase
  endfunction

  state_t               state;
  logic [wordWidth-1:0] shreg;
  logic [1:0]           word_mode;
  logic [CW-1:0]        sym_idx;
  logic [wordWidth-1:0] head_word;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 advance;
  logic                 last_sym;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [ampWidth-1:0]  sym_i;
  logic [ampWidth-1:0]  sym_q;

  // The output register can take a new symbol when it is empty or its
  // current symbol is being accepted this cycle.
  assign advance  = !symValid || symReady;
  assign last_sym = (sym_idx == '0);

  // Popping on the last symbol of a word keeps the stream gap-free.
  assign pop  = start && !fifo_empty &&
                ((state == ST_IDLE) || (advance && last_sym));
  assign push = start && dataValid && (!fifo_full || pop);
  assign drop = start && dataValid && fifo_full && !pop;

  assign busy = !fifo_empty || (state == ST_EMIT) || symValid;

  word_fifo #(
    .wordWidth(wordWidth)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (!start),
    .push      (push),
    .pop       (pop),
    .push_word (dataIn),
    .head_word (head_word),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Map the leading bits of the shift register according to the mode
  // latched with the word.
  always_comb begin
    sym_i = '0;
    sym_q = '0;
    case (word_mode)
      MODE_BPSK: begin
        sym_i = shreg[wordWidth-1] ? PSK_POS : PSK_NEG;
      end
      MODE_QPSK: begin
        sym_i = shreg[wordWidth-1] ? PSK_POS : PSK_NEG;
        sym_q = shreg[wordWidth-2] ? PSK_POS : PSK_NEG;
      end
      default: begin
        sym_i = qam_level(gray_to_index(shreg[wordWidth-1 -: 2]));
        sym_q = qam_level(gray_to_index(shreg[wordWidth-3 -: 2]));
      end
    endcase
  end

  // Unpacker FSM and output register. A pop loads the next word after the
  // emit assignments so it overrides the shift of the finishing word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      word_mode <= MODE_BPSK;
      sym_idx   <= '0;
      symValid  <= 1'b0;
      iOut      <= '0;
      qOut      <= '0;
      symLast   <= 1'b0;
      overflow  <= 1'b0;
    end else if (!start) begin
      state    <= ST_IDLE;
      symValid <= 1'b0;
      iOut     <= '0;
      qOut     <= '0;
      symLast  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= overflow | drop;

      if (state == ST_EMIT && advance) begin
        symValid <= 1'b1;
        iOut     <= sym_i;
        qOut     <= sym_q;
        symLast  <= last_sym;
        shreg    <= shreg << bits_per_symbol(word_mode);
        sym_idx  <= sym_idx - 1'b1;
        if (last_sym && !pop) begin
          state <= ST_IDLE;
        end
      end else if (advance) begin
        symValid <= 1'b0;
      end

      if (pop) begin
        shreg     <= head_word;
        word_mode <= mode;
        sym_idx   <= last_index(mode);
        state     <= ST_EMIT;
      end
    end
  end

endmodule
